// File: rtl/cbud_param.sv
// cbud_param: parametrised up/down counter with terminal-count handling.
// It supports binary wrap, modulo reload and saturate modes.
// There are two outputs at the terminal count:
//   - CAO is a combinational cascade output for ripple chaining.
//   - TC is a registered terminal-count pulse, one cycle late.
// CD clears the counter asynchronously. CS clears it synchronously.

module cbud_param #(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             CD,
    input  logic             CS,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             CAI,
    input  logic             DNUP,
    input  logic [WIDTH-1:0] TCU,
    input  logic [WIDTH-1:0] TCD,
    output logic [WIDTH-1:0] Q,
    output logic             CAO,
    output logic             TC
);

    localparam logic [WIDTH-1:0] ONE_C      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES_C = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_r;
    logic             tc_r;

    logic [WIDTH-1:0] tgt_s;
    logic [WIDTH-1:0] reload_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] cnt_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             at_tc_s;
    logic             count_s;
    logic             tc_next_s;

    // Terminal value in the current direction.
    // Binary mode uses the natural wrap points; the other modes use TCU/TCD.
    always_comb begin
        tgt_s = ZERO_C;
        if (MODE == 0) begin
            tgt_s = DNUP ? ZERO_C : ALL_ONES_C;
        end else begin
            tgt_s = DNUP ? TCD : TCU;
        end
    end

    // Opposite bound, used by modulo mode when it reloads at the terminal.
    always_comb begin
        reload_s = DNUP ? TCU : TCD;
    end

    // Plain +/-1 step that wraps modulo 2^WIDTH.
    // Out-of-range values walk through this step until they reach the terminal.
    always_comb begin
        step_s = ZERO_C;
        if (DNUP) begin
            step_s = q_r - ONE_C;
        end else begin
            step_s = q_r + ONE_C;
        end
    end

    // Terminal detect and count qualifier; both feed the cascade output.
    always_comb begin
        at_tc_s = (q_r == tgt_s);
        count_s = CAI && EN;
    end

    // Value taken on a counting edge, selected by the terminal behaviour of MODE.
    always_comb begin
        cnt_next_s = step_s;
        case (MODE)
            0: begin
                cnt_next_s = step_s;
            end
            1: begin
                if (at_tc_s) begin
                    cnt_next_s = reload_s;
                end else begin
                    cnt_next_s = step_s;
                end
            end
            2: begin
                if (at_tc_s) begin
                    cnt_next_s = q_r;
                end else begin
                    cnt_next_s = step_s;
                end
            end
            default: begin
                cnt_next_s = step_s;
            end
        endcase
    end

    // Edge priority: synchronous clear, then load, then count, otherwise hold.
    always_comb begin
        q_next_s  = q_r;
        tc_next_s = 1'b0;
        if (CS) begin
            q_next_s  = RESET_VAL;
            tc_next_s = 1'b0;
        end else if (LD) begin
            q_next_s  = D;
            tc_next_s = 1'b0;
        end else if (count_s) begin
            q_next_s  = cnt_next_s;
            tc_next_s = at_tc_s;
        end else begin
            q_next_s  = q_r;
            tc_next_s = 1'b0;
        end
    end

    // Counter and terminal-count registers.
    // CD clears them immediately, without waiting for a clock edge.
    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            q_r  <= RESET_VAL;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_next_s;
            tc_r <= tc_next_s;
        end
    end

    assign Q   = q_r;
    assign TC  = tc_r;
    assign CAO = count_s && at_tc_s;

endmodule

// File: tb/tb_cbud_param.sv
// Bench for cbud_param. It builds three instances:
//   - 8-bit binary wrap
//   - 4-bit modulo
//   - 6-bit saturate
// A behavioural model tracks every instance and is compared on each negedge.
// Directed literal checks pin the model to hand-computed values.

module tb_cbud_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic cd, cs, en, cai, dnup;
    logic       ld8, ld4, ld6;
    logic [7:0] d8, tcu8, tcd8, q8;
    logic [3:0] d4, tcu4, tcd4, q4;
    logic [5:0] d6, tcu6, tcd6, q6;
    logic       cao8, cao4, cao6, tc8, tc4, tc6;

    cbud_param #(.WIDTH(8), .MODE(0), .RESET_VAL(8'h05)) u8 (
        .CLK(clk), .CD(cd), .CS(cs), .LD(ld8), .D(d8), .EN(en), .CAI(cai),
        .DNUP(dnup), .TCU(tcu8), .TCD(tcd8), .Q(q8), .CAO(cao8), .TC(tc8));

    cbud_param #(.WIDTH(4), .MODE(1), .RESET_VAL(4'h2)) u4 (
        .CLK(clk), .CD(cd), .CS(cs), .LD(ld4), .D(d4), .EN(en), .CAI(cai),
        .DNUP(dnup), .TCU(tcu4), .TCD(tcd4), .Q(q4), .CAO(cao4), .TC(tc4));

    cbud_param #(.WIDTH(6), .MODE(2), .RESET_VAL(6'h03)) u6 (
        .CLK(clk), .CD(cd), .CS(cs), .LD(ld6), .D(d6), .EN(en), .CAI(cai),
        .DNUP(dnup), .TCU(tcu6), .TCD(tcd6), .Q(q6), .CAO(cao6), .TC(tc6));

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] m8_q, m4_q, m6_q;
    logic        m8_tc, m4_tc, m6_tc;

    function automatic logic [31:0] model_tgt(input int w, input int mode,
                                              input logic [31:0] tcu, input logic [31:0] tcd);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (mode == 0) return dnup ? 32'd0 : mask[31:0];
        return dnup ? tcd : tcu;
    endfunction

    // Returns {tc, q} after one rising edge.
    function automatic logic [32:0] model_next(input int w, input int mode, input logic [31:0] rv,
                                               input logic [31:0] q, input logic ldi, input logic [31:0] d,
                                               input logic [31:0] tcu, input logic [31:0] tcd);
        logic [63:0] mask;
        longint      v;
        logic [63:0] vm;
        logic [31:0] tgt;
        logic        at;
        mask = (64'd1 << w) - 64'd1;
        if (cs)              return {1'b0, rv};
        if (ldi)             return {1'b0, d & mask[31:0]};
        if (!(cai && en))    return {1'b0, q};
        tgt = model_tgt(w, mode, tcu, tcd);
        at  = (q == tgt);
        v   = dnup ? (longint'(q) - 64'sd1) : (longint'(q) + 64'sd1);
        vm  = 64'(v) & mask;
        if (mode == 0) return {at, vm[31:0]};
        if (mode == 1) return {at, at ? (dnup ? tcu : tcd) : vm[31:0]};
        return {at, at ? q : vm[31:0]};
    endfunction

    // Model state: follows CD asynchronously and otherwise advances on each rising edge.
    always @(posedge clk or posedge cd) begin
        if (cd) begin
            m8_q <= 32'h05; m8_tc <= 1'b0;
            m4_q <= 32'h2;  m4_tc <= 1'b0;
            m6_q <= 32'h03; m6_tc <= 1'b0;
        end else begin
            {m8_tc, m8_q} <= model_next(8, 0, 32'h05, m8_q, ld8, 32'(d8), 32'(tcu8), 32'(tcd8));
            {m4_tc, m4_q} <= model_next(4, 1, 32'h2,  m4_q, ld4, 32'(d4), 32'(tcu4), 32'(tcd4));
            {m6_tc, m6_q} <= model_next(6, 2, 32'h03, m6_q, ld6, 32'(d6), 32'(tcu6), 32'(tcd6));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("model_q8",   32'(q8),   m8_q);
        chk("model_tc8",  32'(tc8),  32'(m8_tc));
        chk("model_cao8", 32'(cao8), 32'(cai && en && (m8_q == model_tgt(8, 0, 32'(tcu8), 32'(tcd8)))));
        chk("model_q4",   32'(q4),   m4_q);
        chk("model_tc4",  32'(tc4),  32'(m4_tc));
        chk("model_cao4", 32'(cao4), 32'(cai && en && (m4_q == model_tgt(4, 1, 32'(tcu4), 32'(tcd4)))));
        chk("model_q6",   32'(q6),   m6_q);
        chk("model_tc6",  32'(tc6),  32'(m6_tc));
        chk("model_cao6", 32'(cao6), 32'(cai && en && (m6_q == model_tgt(6, 2, 32'(tcu6), 32'(tcd6)))));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cd = 1'b0; cs = 1'b0; en = 1'b0; cai = 1'b0; dnup = 1'b0;
        ld8 = 1'b0; ld4 = 1'b0; ld6 = 1'b0;
        d8 = 8'h00; d4 = 4'h0; d6 = 6'h00;
        tcu8 = 8'h40; tcd8 = 8'h20;
        tcu4 = 4'd9;  tcd4 = 4'd2;
        tcu6 = 6'd5;  tcd6 = 6'd0;
        #1 cd = 1'b1;
        #3;
        chk("rst_q8", 32'(q8), 32'h05);
        chk("rst_q4", 32'(q4), 32'h2);
        chk("rst_q6", 32'(q6), 32'h03);
        chk("rst_tc", 32'({tc8, tc4, tc6}), 32'h0);
        @(posedge clk); #2;
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none
        cd = 1'b0;

        // Binary wrap going up: 0xFE -> 0xFF (CAO) -> 0x00 (TC).
        ld8 = 1'b1; d8 = 8'hFE; step();
        chk("m0_load", 32'(q8), 32'hFE);
        ld8 = 1'b0; en = 1'b1; cai = 1'b1; dnup = 1'b0;
        step();
        chk("m0_up_ff",  32'(q8),   32'hFF);
        chk("m0_cao",    32'(cao8), 32'h1);
        step();
        chk("m0_wrap",   32'(q8),   32'h00);
        chk("m0_tc_hi",  32'(tc8),  32'h1);
        step();
        chk("m0_tc_lo",  32'(tc8),  32'h0);

        // Binary wrap going down: 0x01 -> 0x00 (CAO) -> 0xFF. EN=0 gates CAO off.
        dnup = 1'b1; ld8 = 1'b1; d8 = 8'h01; step();
        ld8 = 1'b0; step();
        chk("m0_dn_00",  32'(q8),   32'h00);
        chk("m0_dn_cao", 32'(cao8), 32'h1);
        step();
        chk("m0_dn_ff",  32'(q8),   32'hFF);
        ld8 = 1'b1; d8 = 8'h00; step();
        ld8 = 1'b0; en = 1'b0; #1;
        chk("m0_en0_cao", 32'(cao8), 32'h0);
        step();
        chk("m0_en0_hold", 32'(q8), 32'h00);

        // Modulo 4-bit, TCU=9 TCD=2: 2..9, 2, 3.
        // TC is high on the edge after Q=9.
        dnup = 1'b0; en = 1'b1; ld4 = 1'b1; d4 = 4'd2; step();
        chk("m1_load", 32'(q4), 32'h2);
        ld4 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("m1_seq", 32'(q4),  (k <= 7) ? 32'(2 + k) : 32'(k - 6));
            chk("m1_tc",  32'(tc4), (k == 8) ? 32'h1 : 32'h0);
        end
        dnup = 1'b1; ld4 = 1'b1; d4 = 4'd2; step();
        ld4 = 1'b0; step();
        chk("m1_dn_reload", 32'(q4),  32'h9);
        chk("m1_dn_tc",     32'(tc4), 32'h1);
        step();
        chk("m1_dn_8",      32'(q4),  32'h8);

        // Saturate 6-bit, TCU=5 then down to TCD=0.
        dnup = 1'b0; ld6 = 1'b1; d6 = 6'd3; step();
        ld6 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("m2_up",    32'(q6),  (k == 0) ? 32'd4 : 32'd5);
            chk("m2_up_tc", 32'(tc6), (k >= 2) ? 32'h1 : 32'h0);
        end
        dnup = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("m2_dn",    32'(q6),  (k < 4) ? 32'(4 - k) : 32'd0);
            chk("m2_dn_tc", 32'(tc6), (k >= 5) ? 32'h1 : 32'h0);
        end

        // Priority: CS over LD over count.
        dnup = 1'b0; en = 1'b0; ld8 = 1'b1; d8 = 8'h10; step();
        cs = 1'b1; d8 = 8'hAA; en = 1'b1; cai = 1'b1; step();
        chk("pri_cs",    32'(q8),  32'h05);
        chk("pri_cs_tc", 32'(tc8), 32'h0);
        cs = 1'b0; step();
        chk("pri_ld",    32'(q8),  32'hAA);
        chk("pri_ld_tc", 32'(tc8), 32'h0);
        ld8 = 1'b0;

        // Asynchronous clear between edges, then resume counting from RESET_VAL.
        en = 1'b0; ld8 = 1'b1; d8 = 8'h37; step();
        chk("cd_pre", 32'(q8), 32'h37);
        ld8 = 1'b0; en = 1'b1; cai = 1'b1; dnup = 1'b0;
        #1 cd = 1'b1;
        #1;
        chk("cd_async_q8", 32'(q8),  32'h05);
        chk("cd_async_tc", 32'(tc8), 32'h0);
        chk("cd_async_q4", 32'(q4),  32'h2);
        chk("cd_async_q6", 32'(q6),  32'h03);
        step();
        cd = 1'b0;
        step();
        chk("cd_resume_q8", 32'(q8), 32'h06);
        chk("cd_resume_q4", 32'(q4), 32'h3);
        chk("cd_resume_q6", 32'(q6), 32'h04);

        step(); step();
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
